// File: rtl/fpu_pkg.sv
// Shared binary32 format constants for the FPU units.
// Used by finv, fmul and fmul_seq.
package fpu_pkg;
    localparam int EXP_W   = 8;
    localparam int MAN_W   = 23;
    localparam int BIAS    = 127;
    localparam int EXP_MAX = 255;
endpackage

// File: rtl/fmul_seq_if.sv
// Operand/result valid-ready bundle for fmul_seq.
// slave is the multiplier side, master the issuing side.
interface fmul_seq_if;
    logic        valid_in;
    logic        ready_out;
    logic [31:0] x1;
    logic [31:0] x2;
    logic        valid_out;
    logic        ready_in;
    logic [31:0] y;
    logic        ovf;

    modport slave (
        input  valid_in, x1, x2, ready_in,
        output ready_out, valid_out, y, ovf
    );

    modport master (
        output valid_in, x1, x2, ready_in,
        input  ready_out, valid_out, y, ovf
    );
endinterface

// File: rtl/fmul_round.sv
// Normalize, round-to-nearest-even and range check
// of a 48-bit mantissa product into binary32.
module fmul_round
    import fpu_pkg::*;
(
    input  logic [47:0]       p,
    input  logic              s,
    input  logic signed [9:0] e,
    output logic [31:0]       y,
    output logic              ovf
);
    localparam logic signed [9:0] E_MAX = 10'(EXP_MAX);

    logic [MAN_W-1:0]  man;
    logic [MAN_W-1:0]  man_r;
    logic              g;
    logic              st;
    logic              inc;
    logic              cy;
    logic signed [9:0] ex;
    logic signed [9:0] ef;

    // select window, round, then clamp to the finite range
    always_comb begin
        if (p[47]) begin
            man = p[46:24];
            g   = p[23];
            st  = |p[22:0];
            ex  = e + 10'sd1;
        end else begin
            man = p[45:23];
            g   = p[22];
            st  = |p[21:0];
            ex  = e;
        end
        inc         = g & (st | man[0]);
        {cy, man_r} = {1'b0, man} + {{MAN_W{1'b0}}, inc};
        ef          = cy ? ex + 10'sd1 : ex;
        y           = '0;
        ovf         = 1'b0;
        if (ef >= E_MAX) begin
            y   = {s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            ovf = 1'b1;
        end else if (ef <= 10'sd0) begin
            ovf = 1'b1;
        end else begin
            y = {s, ef[7:0], man_r};
        end
    end
endmodule

// File: rtl/fmul_seq.sv
// Sequential binary32 multiplier: 24-cycle shift-and-add
// mantissa product followed by one normalize/round cycle.
module fmul_seq
    import fpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    fmul_seq_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

    localparam logic [4:0]        LAST   = 5'(MAN_W);
    localparam logic signed [9:0] BIAS_S = 10'(BIAS);

    state_t            state_q;
    state_t            state_d;
    logic [23:0]       m1_q;
    logic [23:0]       m2_q;
    logic              s_q;
    logic signed [9:0] e_q;
    logic [47:0]       acc_q;
    logic [4:0]        count_q;
    logic [31:0]       y_q;
    logic              ovf_q;
    logic [31:0]       y_r;
    logic              ovf_r;
    logic              zero_op;
    logic              accept;

    assign accept  = bus.valid_in && (state_q == IDLE);
    assign zero_op = (bus.x1[MAN_W +: EXP_W] == '0) ||
                     (bus.x2[MAN_W +: EXP_W] == '0);

    fmul_round u_round (
        .p   (acc_q),
        .s   (s_q),
        .e   (e_q),
        .y   (y_r),
        .ovf (ovf_r)
    );

    // state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = zero_op ? DONE : MUL;
            MUL:  if (count_q == LAST) state_d = NORM;
            NORM: state_d = DONE;
            DONE: if (bus.ready_in) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // operand capture, accumulation and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            m1_q    <= '0;
            m2_q    <= '0;
            s_q     <= 1'b0;
            e_q     <= '0;
            acc_q   <= '0;
            count_q <= '0;
            y_q     <= '0;
            ovf_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: if (accept) begin
                    m1_q    <= {1'b1, bus.x1[MAN_W-1:0]};
                    m2_q    <= {1'b1, bus.x2[MAN_W-1:0]};
                    s_q     <= bus.x1[31] ^ bus.x2[31];
                    e_q     <= $signed({2'b00, bus.x1[MAN_W +: EXP_W]})
                             + $signed({2'b00, bus.x2[MAN_W +: EXP_W]})
                             - BIAS_S;
                    acc_q   <= '0;
                    count_q <= '0;
                    if (zero_op) begin
                        y_q   <= '0;
                        ovf_q <= 1'b0;
                    end
                end
                MUL: begin
                    if (m2_q[count_q])
                        acc_q <= acc_q + ({24'd0, m1_q} << count_q);
                    count_q <= count_q + 5'd1;
                end
                NORM: begin
                    y_q   <= y_r;
                    ovf_q <= ovf_r;
                end
                default: ;
            endcase
        end
    end

    assign bus.ready_out = (state_q == IDLE);
    assign bus.valid_out = (state_q == DONE);
    assign bus.y         = y_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_fmul_seq.sv
// Directed vector bench for fmul_seq: products, rounding,
// range errors, latency, back-pressure and reset abort.
module tb_fmul_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    fmul_seq_if bus();

    fmul_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] y;
        logic        ovf;
        int          lat;
    } vec_t;

    vec_t vt[11];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // lat = clock edges after the accepting edge until valid_out is seen
    // (0 means visible in the cycle right after the accepting edge)
    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] y, output logic o,
                         output int lat);
        int w = 0;
        while (!bus.ready_out && w < 100) begin
            @(posedge clk); #1; w++;
        end
        bus.valid_in = 1'b1;
        bus.x1       = a;
        bus.x2       = b;
        @(posedge clk); #1;
        bus.valid_in = 1'b0;
        lat = 0;
        while (!bus.valid_out && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        y = bus.y;
        o = bus.ovf;
    endtask

    task automatic release_res(input string name);
        bus.ready_in = 1'b1;
        @(posedge clk); #1;
        bus.ready_in = 1'b0;
        chk({name, "_ready_out"}, 32'(bus.ready_out), 32'd1);
        chk({name, "_valid_low"}, 32'(bus.valid_out), 32'd0);
    endtask

    initial begin
        logic [31:0] y;
        logic        o;
        int          lat;
        int          seen;

        vt[0]  = '{32'h40000000, 32'h40400000, 32'h40C00000, 1'b0, 25};
        vt[1]  = '{32'hC0000000, 32'h40400000, 32'hC0C00000, 1'b0, 25};
        vt[2]  = '{32'h3FC00000, 32'h3FC00000, 32'h40100000, 1'b0, 25};
        vt[3]  = '{32'h3F800001, 32'h3F800001, 32'h3F800002, 1'b0, 25};
        vt[4]  = '{32'h3F800800, 32'h3F800800, 32'h3F801000, 1'b0, 25};
        vt[5]  = '{32'h00000000, 32'h40A00000, 32'h00000000, 1'b0, 0};
        vt[6]  = '{32'h40A00000, 32'h00000000, 32'h00000000, 1'b0, 0};
        vt[7]  = '{32'h7F000000, 32'h40000000, 32'h7F800000, 1'b1, 25};
        vt[8]  = '{32'h00800000, 32'h3F000000, 32'h00000000, 1'b1, 25};
        vt[9]  = '{32'hC0000000, 32'hC0400000, 32'h40C00000, 1'b0, 25};
        vt[10] = '{32'h3FC00001, 32'h3FC00001, 32'h40100002, 1'b0, 25};

        bus.valid_in = 1'b0;
        bus.ready_in = 1'b0;
        bus.x1       = '0;
        bus.x2       = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_ready_out", 32'(bus.ready_out), 32'd1);
        chk("rst_valid_out", 32'(bus.valid_out), 32'd0);
        chk("rst_y", bus.y, 32'h0);
        chk("rst_ovf", 32'(bus.ovf), 32'd0);

        for (int i = 0; i < 11; i++) begin
            do_op(vt[i].a, vt[i].b, y, o, lat);
            chk($sformatf("v%0d_y", i), y, vt[i].y);
            chk($sformatf("v%0d_ovf", i), 32'(o), 32'(vt[i].ovf));
            chk($sformatf("v%0d_lat", i), 32'(lat), 32'(vt[i].lat));
            release_res($sformatf("v%0d", i));
        end

        // back-pressure: result held while the inputs churn
        do_op(32'h40000000, 32'h40400000, y, o, lat);
        chk("bp_first_y", y, 32'h40C00000);
        for (int i = 0; i < 5; i++) begin
            bus.valid_in = ~bus.valid_in;
            bus.x1       = $urandom;
            bus.x2       = $urandom;
            @(posedge clk); #1;
            chk($sformatf("bp%0d_y", i), bus.y, 32'h40C00000);
            chk($sformatf("bp%0d_valid", i), 32'(bus.valid_out), 32'd1);
            chk($sformatf("bp%0d_ready_out", i), 32'(bus.ready_out), 32'd0);
        end
        bus.valid_in = 1'b0;
        release_res("bp");
        do_op(32'h3FC00000, 32'h3FC00000, y, o, lat);
        chk("bp_next_y", y, 32'h40100000);
        chk("bp_next_lat", 32'(lat), 32'd25);
        release_res("bp_next");

        // reset while MUL is at count 10
        bus.valid_in = 1'b1;
        bus.x1       = 32'h40000000;
        bus.x2       = 32'h40400000;
        @(posedge clk); #1;
        bus.valid_in = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mrst_ready_out", 32'(bus.ready_out), 32'd1);
        chk("mrst_valid_out", 32'(bus.valid_out), 32'd0);
        chk("mrst_y", bus.y, 32'h0);
        seen = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (bus.valid_out) seen++;
        end
        chk("mrst_no_stale", 32'(seen), 32'd0);
        do_op(32'h40000000, 32'h40400000, y, o, lat);
        chk("mrst_after_y", y, 32'h40C00000);
        chk("mrst_after_ovf", 32'(o), 32'd0);
        release_res("mrst_after");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
